// File: rtl/mha_pkg.sv
// Shared definitions for the MHA partial-sum accumulator controller.
//   state_e        : controller states (2-bit encoding)
//   ACC_WIDTH      : default per-lane partial-product width
//   ACTUAL_WIDTH   : default per-lane accumulator width
//   SYSTOLIC_COLUMN: default lanes per PE block
//   PE_BLK_COUNT   : default number of PE blocks
//   LANES          : default total lane count
package mha_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int ACC_WIDTH       = 18;
  localparam int ACTUAL_WIDTH    = 21;
  localparam int SYSTOLIC_COLUMN = 16;
  localparam int PE_BLK_COUNT    = 16;
  localparam int LANES           = PE_BLK_COUNT * SYSTOLIC_COLUMN;

endpackage

// File: rtl/mha_accum_ctrl_accumulator.sv
// Combinational lane-wise adder array.
//   a_i   : lanes x acc_width partial products (two's complement)
//   b_i   : lanes x actual_width running sums
//   sum_o : lanes x actual_width, sign_extend(a) + b per lane, wrapping
module Accumulator #(
  parameter int acc_width    = 18,
  parameter int actual_width = 21,
  parameter int lanes        = 256
) (
  input  logic [lanes*acc_width-1:0]    a_i,
  input  logic [lanes*actual_width-1:0] b_i,
  output logic [lanes*actual_width-1:0] sum_o
);

  for (genvar i = 0; i < lanes; i++) begin : g_lane
    logic [acc_width-1:0]    a_lane;
    logic [actual_width-1:0] a_ext;

    assign a_lane = a_i[i*acc_width +: acc_width];
    assign a_ext  = {{(actual_width-acc_width){a_lane[acc_width-1]}}, a_lane};
    // Carry out of the top bit is dropped: modular wrap is intended.
    assign sum_o[i*actual_width +: actual_width] =
      a_ext + b_i[i*actual_width +: actual_width];
  end

endmodule

// File: rtl/mha_accum_ctrl.sv
// Sequencing controller for the MHA partial-sum accumulator bank.
//   clk, rst_n          : clock, async active-low reset
//   start, cfg_num_chunks: begin a tile of cfg_num_chunks beats (IDLE only)
//   abort               : synchronous cancel back to IDLE, no done
//   busy, cfg_err, done : status; cfg_err/done are one-cycle pulses
//   in_valid/in_ready/in_data   : partial-product beat handshake
//   out_valid/out_ready/out_data: final-sum handshake
//
// state | meaning
// IDLE  | waiting for start; bank holds last (or stale) sums
// ACCUM | accepting beats, adding each into the bank
// DRAIN | presenting the bank until downstream accepts
module mha_accum_ctrl
  import mha_pkg::*;
#(
  parameter int acc_width       = ACC_WIDTH,
  parameter int actual_width    = ACTUAL_WIDTH,
  parameter int systolic_column = SYSTOLIC_COLUMN,
  parameter int pe_blk_count    = PE_BLK_COUNT,
  parameter int cnt_width       = 6
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic                                              start,
  input  logic [cnt_width-1:0]                              cfg_num_chunks,
  input  logic                                              abort,
  output logic                                              busy,
  output logic                                              cfg_err,
  input  logic                                              in_valid,
  output logic                                              in_ready,
  input  logic [pe_blk_count*systolic_column*acc_width-1:0] in_data,
  output logic                                              out_valid,
  input  logic                                              out_ready,
  output logic [pe_blk_count*systolic_column*actual_width-1:0] out_data,
  output logic                                              done
);

  localparam int lanes = pe_blk_count * systolic_column;

  state_e                          state_q, state_d;
  logic [cnt_width-1:0]            cnt_q, cnt_d;
  logic [cnt_width-1:0]            num_q, num_d;
  logic [lanes*actual_width-1:0]   acc_q, acc_d;
  logic [lanes*actual_width-1:0]   sum;
  logic                            done_q, done_d;
  logic                            cfg_err_q, cfg_err_d;
  logic                            start_ok;
  logic                            beat;
  logic                            last_beat;

  Accumulator #(
    .acc_width    (acc_width),
    .actual_width (actual_width),
    .lanes        (lanes)
  ) u_adders (
    .a_i   (in_data),
    .b_i   (acc_q),
    .sum_o (sum)
  );

  assign start_ok  = (state_q == IDLE) && start && (cfg_num_chunks != '0) && !abort;
  assign beat      = (state_q == ACCUM) && in_valid && !abort;
  assign last_beat = beat && (cnt_q == (num_q - cnt_width'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      num_q     <= '0;
      acc_q     <= '0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      num_q     <= num_d;
      acc_q     <= acc_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_ok) state_d = ACCUM;
        ACCUM:   if (last_beat) state_d = DRAIN;
        DRAIN:   if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath: clear on accepted start, add on accepted beat, else hold.
  // Abort leaves the bank stale by design.
  always_comb begin
    cnt_d     = cnt_q;
    num_d     = num_q;
    acc_d     = acc_q;
    done_d    = (state_q == DRAIN) && out_ready && !abort;
    cfg_err_d = (state_q == IDLE) && start && (cfg_num_chunks == '0) && !abort;
    if (start_ok) begin
      cnt_d = '0;
      num_d = cfg_num_chunks;
      acc_d = '0;
    end else if (beat) begin
      cnt_d = cnt_q + cnt_width'(1);
      acc_d = sum;
    end
  end

  always_comb begin
    busy      = (state_q != IDLE);
    in_ready  = (state_q == ACCUM);
    out_valid = (state_q == DRAIN);
    out_data  = acc_q;
    done      = done_q;
    cfg_err   = cfg_err_q;
  end

endmodule

// File: tb/tb_mha_accum_ctrl.sv
module tb_mha_accum_ctrl;

  localparam int AW = 18;
  localparam int RW = 21;
  localparam int NL = 256;
  localparam int CW = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [CW-1:0]     cfg_num_chunks = '0;
  logic              abort = 1'b0;
  logic              busy, cfg_err, in_ready, out_valid, done;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic [NL*AW-1:0]  in_data = '0;
  logic [NL*RW-1:0]  out_data;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mha_accum_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .cfg_num_chunks (cfg_num_chunks),
    .abort          (abort),
    .busy           (busy),
    .cfg_err        (cfg_err),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .done           (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_all(input logic [AW-1:0] v);
    for (int i = 0; i < NL; i++) in_data[i*AW +: AW] = v;
  endtask

  // Compares every lane against exp; reports the first offending lane.
  task automatic chk_all(input string tag, input logic [RW-1:0] exp);
    int idx = 0;
    for (int i = NL-1; i >= 0; i--)
      if (out_data[i*RW +: RW] !== exp) idx = i;
    chk($sformatf("%s lane%0d", tag, idx), 32'(out_data[idx*RW +: RW]), 32'(exp));
  endtask

  task automatic start_tile(input int n);
    start = 1'b1;
    cfg_num_chunks = CW'(n);
    tick();
    start = 1'b0;
    chk("start busy", 32'(busy), 32'd1);
    chk("start in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic beat(input logic [AW-1:0] v);
    set_all(v);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " busy after"}, 32'(busy), 32'd0);
    tick();
    chk({tag, " done 1cyc"}, 32'(done), 32'd0);
  endtask

  initial begin
    // reset state
    #12;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst cfg_err", 32'(cfg_err), 32'd0);
    chk_all("rst out_data", 21'd0);
    rst_n = 1'b1;
    tick();

    // reset mid-ACCUM
    start_tile(4);
    beat(18'd3);
    beat(18'd3);
    rst_n = 1'b0;
    #1;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst in_ready", 32'(in_ready), 32'd0);
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    start_tile(1);
    beat(18'd5);
    chk("n1 out_valid", 32'(out_valid), 32'd1);
    chk_all("n1 sum", 21'd5);
    handshake("n1");

    // basic tile: 7 + 7 - 2
    start_tile(3);
    beat(18'd7);
    beat(18'd7);
    chk("basic not yet valid", 32'(out_valid), 32'd0);
    beat(18'h3FFFE);
    chk("basic out_valid", 32'(out_valid), 32'd1);
    chk_all("basic sum", 21'd12);
    handshake("basic");

    // bubbles and backpressure: 1+2+3+4 with idle cycles carrying junk
    start_tile(4);
    for (int k = 1; k <= 4; k++) begin
      beat(AW'(k));
      if (k < 4) begin
        set_all(18'd100);
        tick();
      end
    end
    for (int s = 0; s < 5; s++) begin
      chk($sformatf("stall%0d out_valid", s), 32'(out_valid), 32'd1);
      chk_all($sformatf("stall%0d sum", s), 21'd10);
      tick();
    end
    chk("stall no done", 32'(done), 32'd0);
    handshake("bubble");

    // wrap: lane0 max positive, lane255 = -1, others zero, 16 beats
    start_tile(16);
    for (int k = 0; k < 16; k++) begin
      in_data = '0;
      in_data[0 +: AW] = 18'h1FFFF;
      in_data[255*AW +: AW] = 18'h3FFFF;
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("wrap out_valid", 32'(out_valid), 32'd1);
    chk("wrap lane0", 32'(out_data[0 +: RW]), 32'h1FFFF0);
    chk("wrap lane255", 32'(out_data[255*RW +: RW]), 32'h1FFFF0);
    chk("wrap lane1", 32'(out_data[1*RW +: RW]), 32'd0);
    handshake("wrap");

    // zero config
    start = 1'b1;
    cfg_num_chunks = '0;
    tick();
    start = 1'b0;
    chk("zero cfg_err", 32'(cfg_err), 32'd1);
    chk("zero busy", 32'(busy), 32'd0);
    tick();
    chk("zero cfg_err 1cyc", 32'(cfg_err), 32'd0);

    // start spam during ACCUM is ignored
    start_tile(2);
    start = 1'b1;
    cfg_num_chunks = CW'(5);
    beat(18'd4);
    chk("spam not valid", 32'(out_valid), 32'd0);
    chk("spam busy", 32'(busy), 32'd1);
    chk("spam no cfg_err", 32'(cfg_err), 32'd0);
    beat(18'd6);
    start = 1'b0;
    chk("spam out_valid", 32'(out_valid), 32'd1);
    chk_all("spam sum", 21'd10);
    handshake("spam");

    // abort in DRAIN beats out_ready
    start_tile(1);
    beat(18'd9);
    chk("abort pre out_valid", 32'(out_valid), 32'd1);
    abort = 1'b1;
    out_ready = 1'b1;
    tick();
    abort = 1'b0;
    out_ready = 1'b0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort no done", 32'(done), 32'd0);
    tick();
    chk("abort no done later", 32'(done), 32'd0);
    start_tile(2);
    beat(18'd1);
    beat(18'd1);
    chk("post-abort out_valid", 32'(out_valid), 32'd1);
    chk_all("post-abort sum", 21'd2);
    handshake("post-abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mha_accum_ctrl.md
# mha_accum_ctrl

Sequencing controller for the MHA partial-sum accumulator. It owns the `pe_blk_count × systolic_column` bank of `actual_width` accumulators and a combinational adder array. It accepts `cfg_num_chunks` partial-product beats from the systolic array over a valid/ready handshake, sums them lane by lane into the bank, then presents the final sums downstream through a second valid/ready handshake. It sits between the systolic PE blocks and the softmax/output stage of each attention tile.

## Interface
Parameters:
- `acc_width`, 18: per-lane width of incoming partial products (two's complement).
- `actual_width`, 21: per-lane accumulator width.
- `systolic_column`, 16: lanes per PE block.
- `pe_blk_count`, 16: PE blocks.
- `cnt_width`, 6: width of the chunk counter and `cfg_num_chunks`.

Ports:
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `start`  in  1: begin a tile; honoured only in IDLE.
- `cfg_num_chunks`  in  cnt_width: beats per tile; sampled on accepted `start`.
- `abort`  in  1: synchronous cancel; returns to IDLE with no `done`.
- `busy`  out  1: high when state ≠ IDLE.
- `cfg_err`  out  1: one-cycle pulse when `start` arrives with `cfg_num_chunks == 0`.
- `in_valid`  in  1: partial-product beat valid.
- `in_ready`  out  1: accepting beats.
- `in_data`  in  pe_blk_count·systolic_column·acc_width: lane i occupies bits [acc_width·(i+1)-1 : acc_width·i]; lane index = blk·systolic_column + col.
- `out_valid`  out  1: final sums valid.
- `out_ready`  in  1: downstream accepts.
- `out_data`  out  pe_blk_count·systolic_column·actual_width: same lane packing at `actual_width`.
- `done`  out  1: one-cycle pulse after the output handshake.

## Operation
States: IDLE, ACCUM, DRAIN (2-bit encoding).

- **IDLE:** `in_ready = 0`, `out_valid = 0`.
  - `start && cfg_num_chunks != 0`: latch N, clear all accumulators to 0, clear `cnt` to 0, go to ACCUM.
  - `start && cfg_num_chunks == 0`: pulse `cfg_err` next cycle, stay in IDLE.
- **ACCUM:** `in_ready = 1`.
  - On each `in_valid && in_ready`: every lane's `acc <= acc + sign_extend(in_lane)`, and `cnt` increments.
  - The beat with `cnt == N-1` also moves the state to DRAIN.
  - Cycles with `in_valid` low leave `acc` and `cnt` unchanged.
- **DRAIN:** `out_valid = 1`, `out_data = acc` (held stable).
  - On `out_ready`: go to IDLE and pulse `done` in the following cycle.
- **Arithmetic:** each lane is summed modulo 2^actual_width. There is no saturation and no overflow flag; wrap is required behaviour.
- **`abort`:** in any state, go to IDLE next cycle. Accumulators keep their stale values and `done` does not pulse. `abort` has priority over every handshake in the same cycle.
- **`start` outside IDLE:** ignored and not queued. `cfg_num_chunks` changes after sampling have no effect.
- **`rst_n` low at any time:** state = IDLE, `cnt` = 0, all accumulators = 0, all outputs low, `out_data` = 0.

## Timing
- Reset values: `busy`, `in_ready`, `out_valid`, `done`, `cfg_err` are 0, and `out_data` is all zeros.
- `in_ready`, `out_valid` and `busy` are decoded from registered state only. They have no combinational path from `in_valid` or `out_ready`.
- `start` accepted at cycle t: `busy` and `in_ready` are high at t+1.
- Throughput is one beat per cycle with no bubbles. N beats back-to-back from t+1 finish at t+N, and `out_valid` is high at t+N+1.
- Last beat accepted at cycle u: `out_valid` is high at u+1 and `out_data` holds the complete sum.
- Output handshake at cycle v: `done` = 1 and `busy` = 0 at v+1. A new `start` is accepted at v+1.
- `cfg_err` is high for exactly one cycle, the cycle after the rejected `start`.
- `out_ready` held high in DRAIN: exactly one cycle of `out_valid`.

## Structure
- Shared package `mha_pkg`:
  - state enum `IDLE/ACCUM/DRAIN`
  - default widths (`ACC_WIDTH = 18`, `ACTUAL_WIDTH = 21`, `SYSTOLIC_COLUMN = 16`, `PE_BLK_COUNT = 16`)
  - lane-count constant `LANES = PE_BLK_COUNT*SYSTOLIC_COLUMN`
- One sub-module: the existing combinational `Accumulator` adder array, instantiated once. Its A input is `in_data`, its B input is the accumulator bank, and its sum feeds the bank's D input gated by the beat-accept enable. The clear in IDLE muxes 0 into the bank.
- FSM, counter, bank registers and handshake logic live in `mha_accum_ctrl`.

## Test plan
- **Reset mid-ACCUM:** drop `rst_n` after 2 of 4 beats → `busy`, `in_ready`, `out_valid` low immediately. A fresh `start` with N = 1 and all lanes = 5 → `out_data` lanes = 5, showing no residue from the aborted tile.
- **Basic tile:** N = 3, all lanes = +7, then +7, then -2 → at u+1 `out_valid` = 1 and every lane = 12. `done` pulses once after `out_ready`.
- **Bubbles and backpressure:** N = 4 with `in_valid` toggled 1010… and `out_ready` held low 5 cycles in DRAIN → sum is correct, `out_data` is stable during stall, `done` comes at handshake+1.
- **Wrap:** N = 16, lane 0 = 0x1FFFF (max positive 18-bit) every beat → lane 0 = (16·131071) mod 2^21 = 0x1FFFF0 (two's complement wrap). Lane 255 = -1 ×16 → 0x1FFFF0.
- **Zero config and start spam:** `start` with N = 0 → `cfg_err` one-cycle pulse and `busy` stays 0. `start` pulsed during ACCUM → ignored and the beat count is unchanged.
- **Abort:** `abort` in DRAIN together with `out_ready` → IDLE next cycle, no `done`. The next tile with N = 2, lanes 1, 1 → lanes = 2.
